// File: rtl/pa_ahbl_arb_if.sv
// Bundle of all signals between the BMU buses, the ibus/dbus arbiter and the
// pad AHB-Lite port.
//   master modport : arbiter view (it is the AHB-Lite master towards the pad)
//   slave  modport : environment view (BMU requesters plus pad slave response)
// Signals:
//   ibus_* / dbus_*   request side: req, addr, size, prot (+write, wdata, lock on dbus)
//   *_grnt/*_cmplt/*_err, arb_rdata   per-bus grant, completion, error, read data
//   ahbl_*            AHB-Lite address/control/write-data outputs
//   pad_*             AHB-Lite slave response (hrdata, hready, hresp)
//   arb_idle          arbiter idle with no pending request
interface pa_ahbl_arb_if;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic [1:0]  ibus_size;
   logic [3:0]  ibus_prot;
   logic        dbus_req;
   logic [31:0] dbus_addr;
   logic [1:0]  dbus_size;
   logic [3:0]  dbus_prot;
   logic        dbus_write;
   logic [31:0] dbus_wdata;
   logic        dbus_lock;
   logic        ibus_grnt;
   logic        dbus_grnt;
   logic        ibus_cmplt;
   logic        dbus_cmplt;
   logic        ibus_err;
   logic        dbus_err;
   logic [31:0] arb_rdata;
   logic [31:0] ahbl_haddr;
   logic [1:0]  ahbl_htrans;
   logic        ahbl_hwrite;
   logic [2:0]  ahbl_hsize;
   logic [3:0]  ahbl_hprot;
   logic        ahbl_hlock;
   logic [31:0] ahbl_hwdata;
   logic [31:0] pad_hrdata;
   logic        pad_hready;
   logic        pad_hresp;
   logic        arb_idle;

   modport master (
      input  ibus_req, ibus_addr, ibus_size, ibus_prot,
      input  dbus_req, dbus_addr, dbus_size, dbus_prot, dbus_write, dbus_wdata, dbus_lock,
      input  pad_hrdata, pad_hready, pad_hresp,
      output ibus_grnt, dbus_grnt, ibus_cmplt, dbus_cmplt, ibus_err, dbus_err, arb_rdata,
      output ahbl_haddr, ahbl_htrans, ahbl_hwrite, ahbl_hsize, ahbl_hprot, ahbl_hlock,
      output ahbl_hwdata, arb_idle
   );

   modport slave (
      output ibus_req, ibus_addr, ibus_size, ibus_prot,
      output dbus_req, dbus_addr, dbus_size, dbus_prot, dbus_write, dbus_wdata, dbus_lock,
      output pad_hrdata, pad_hready, pad_hresp,
      input  ibus_grnt, dbus_grnt, ibus_cmplt, dbus_cmplt, ibus_err, dbus_err, arb_rdata,
      input  ahbl_haddr, ahbl_htrans, ahbl_hwrite, ahbl_hsize, ahbl_hprot, ahbl_hlock,
      input  ahbl_hwdata, arb_idle
   );
endinterface

// File: rtl/pa_ahbl_arb.sv
// Shares one AHB-Lite master port between the BMU instruction bus and data bus.
// One transfer at a time: IDLE (arbitrate/grant) -> ADDR -> DATA -> IDLE, with a
// registered completion pulse, error flag and read data returned to the owner.
// Ports:
//   forever_cpuclk  clock
//   cpurst_b        asynchronous active-low reset
//   bus             pa_ahbl_arb_if.master: requests, grants/completions, AHB-Lite port
module pa_ahbl_arb #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic           forever_cpuclk,
   input  logic           cpurst_b,
   pa_ahbl_arb_if.master  bus
);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_ibus_win;
   logic               w_dbus_win;
   logic               w_starved;
   logic               w_cmplt_gap;
   logic [CNT_W-1:0]   r_starve_cnt;
   logic               r_lock_own;
   logic               r_owner_d;
   logic [31:0]        r_wdata;
   logic [31:0]        r_haddr;
   logic [1:0]         r_htrans;
   logic               r_hwrite;
   logic [2:0]         r_hsize;
   logic [3:0]         r_hprot;
   logic               r_hlock;
   logic [31:0]        r_hwdata;
   logic               r_ibus_cmplt;
   logic               r_dbus_cmplt;
   logic               r_ibus_err;
   logic               r_dbus_err;
   logic [31:0]        r_rdata;

   assign w_starved   = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
   // Completion cycle is also an IDLE cycle; hold off the next grant by one so
   // the requester sees cmplt before any new grant.
   assign w_cmplt_gap = r_ibus_cmplt | r_dbus_cmplt;

   // State register
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next state and arbitration
   always_comb begin
      w_state_nxt = r_state;
      w_ibus_win  = 1'b0;
      w_dbus_win  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_cmplt_gap) begin
               if (r_lock_own) begin
                  w_dbus_win = bus.dbus_req;
               end else if (bus.ibus_req && bus.dbus_req) begin
                  w_ibus_win = w_starved;
                  w_dbus_win = !w_starved;
               end else begin
                  w_ibus_win = bus.ibus_req;
                  w_dbus_win = bus.dbus_req;
               end
            end
            if (w_ibus_win || w_dbus_win) w_state_nxt = ST_ADDR;
         end
         ST_ADDR: if (bus.pad_hready) w_state_nxt = ST_DATA;
         ST_DATA: if (bus.pad_hready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Starvation counter and locked-sequence ownership
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_starve_cnt <= '0;
         r_lock_own   <= 1'b0;
      end else begin
         if (w_ibus_win || !bus.ibus_req)
            r_starve_cnt <= '0;
         else if (w_dbus_win && !w_starved)
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);

         if (r_state == ST_IDLE) begin
            if (w_dbus_win && bus.dbus_lock) r_lock_own <= 1'b1;
            else if (!bus.dbus_lock)         r_lock_own <= 1'b0;
         end
      end
   end

   // Transfer capture, AHB-Lite drive and completion return
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_owner_d    <= 1'b0;
         r_wdata      <= '0;
         r_haddr      <= '0;
         r_htrans     <= HTRANS_IDLE;
         r_hwrite     <= 1'b0;
         r_hsize      <= '0;
         r_hprot      <= '0;
         r_hlock      <= 1'b0;
         r_hwdata     <= '0;
         r_ibus_cmplt <= 1'b0;
         r_dbus_cmplt <= 1'b0;
         r_ibus_err   <= 1'b0;
         r_dbus_err   <= 1'b0;
         r_rdata      <= '0;
      end else begin
         r_ibus_cmplt <= 1'b0;
         r_dbus_cmplt <= 1'b0;
         r_ibus_err   <= 1'b0;
         r_dbus_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_ibus_win) begin
                  r_owner_d <= 1'b0;
                  r_haddr   <= bus.ibus_addr;
                  r_hsize   <= {1'b0, bus.ibus_size};
                  r_hprot   <= bus.ibus_prot;
                  r_hwrite  <= 1'b0;
                  r_wdata   <= '0;
                  r_hlock   <= 1'b0;
                  r_htrans  <= HTRANS_NONSEQ;
               end else if (w_dbus_win) begin
                  r_owner_d <= 1'b1;
                  r_haddr   <= bus.dbus_addr;
                  r_hsize   <= {1'b0, bus.dbus_size};
                  r_hprot   <= bus.dbus_prot;
                  r_hwrite  <= bus.dbus_write;
                  r_wdata   <= bus.dbus_wdata;
                  r_hlock   <= bus.dbus_lock;
                  r_htrans  <= HTRANS_NONSEQ;
               end
            end
            ST_ADDR: begin
               if (bus.pad_hready) begin
                  r_htrans <= HTRANS_IDLE;
                  r_hwdata <= r_hwrite ? r_wdata : 32'h0;
               end
            end
            ST_DATA: begin
               // hresp with hready low is the first ERROR cycle; only the
               // hready-high cycle ends the transfer.
               if (bus.pad_hready) begin
                  r_hwdata     <= '0;
                  r_ibus_cmplt <= !r_owner_d;
                  r_dbus_cmplt <= r_owner_d;
                  r_ibus_err   <= !r_owner_d && bus.pad_hresp;
                  r_dbus_err   <= r_owner_d && bus.pad_hresp;
                  r_rdata      <= bus.pad_hrdata;
               end
            end
            default: r_htrans <= HTRANS_IDLE;
         endcase
      end
   end

   assign bus.ibus_grnt   = w_ibus_win;
   assign bus.dbus_grnt   = w_dbus_win;
   assign bus.ibus_cmplt  = r_ibus_cmplt;
   assign bus.dbus_cmplt  = r_dbus_cmplt;
   assign bus.ibus_err    = r_ibus_err;
   assign bus.dbus_err    = r_dbus_err;
   assign bus.arb_rdata   = r_rdata;
   assign bus.ahbl_haddr  = r_haddr;
   assign bus.ahbl_htrans = r_htrans;
   assign bus.ahbl_hwrite = r_hwrite;
   assign bus.ahbl_hsize  = r_hsize;
   assign bus.ahbl_hprot  = r_hprot;
   assign bus.ahbl_hlock  = r_hlock;
   assign bus.ahbl_hwdata = r_hwdata;
   assign bus.arb_idle    = (r_state == ST_IDLE) && !bus.ibus_req && !bus.dbus_req;
endmodule

// File: tb/tb_pa_ahbl_arb.sv
// Directed bench for pa_ahbl_arb: stimulus pushes expected grants and
// completions into queues, a negedge monitor pops and compares them.
module tb_pa_ahbl_arb;
   logic clk;
   logic rst_n;
   int   cyc;
   int   n_tests;
   int   n_fail;

   typedef struct {
      logic        owner_d;
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } cexp_t;

   logic  g_q[$];
   cexp_t c_q[$];

   pa_ahbl_arb_if bus();

   pa_ahbl_arb #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_n),
      .bus            (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_c(input logic owner_d, input logic err, input logic [31:0] rdata,
                         input int exp_cyc);
      cexp_t e;
      e.owner_d = owner_d;
      e.err     = err;
      e.rdata   = rdata;
      e.cyc     = exp_cyc;
      c_q.push_back(e);
   endtask

   task automatic wait_any(input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (bus.ibus_grnt || bus.dbus_grnt) got = 1'b1;
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL grant_timeout: no grant within %0d cycles", budget);
      end
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && (g_q.size() != 0 || c_q.size() != 0); i++)
         @(posedge clk);
      chk("queues_drained", 32'(g_q.size() + c_q.size()), 32'd0);
      #1;
   endtask

   // Monitor: every grant/completion pulse must match the head of its queue
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ibus_grnt || bus.dbus_grnt) begin
            if (g_q.size() == 0) begin
               chk("grant_unexpected", 32'({bus.ibus_grnt, bus.dbus_grnt}), 32'd0);
            end else begin
               logic gd;
               gd = g_q.pop_front();
               chk("grant_owner", 32'({bus.ibus_grnt, bus.dbus_grnt}),
                   gd ? 32'd1 : 32'd2);
            end
         end
         if (bus.ibus_cmplt || bus.dbus_cmplt) begin
            if (c_q.size() == 0) begin
               chk("cmplt_unexpected", 32'({bus.ibus_cmplt, bus.dbus_cmplt}), 32'd0);
            end else begin
               cexp_t e;
               e = c_q.pop_front();
               chk("cmplt_owner", 32'({bus.ibus_cmplt, bus.dbus_cmplt}),
                   e.owner_d ? 32'd1 : 32'd2);
               chk("cmplt_err", 32'({bus.ibus_err, bus.dbus_err}),
                   !e.err ? 32'd0 : (e.owner_d ? 32'd1 : 32'd2));
               chk("cmplt_rdata", bus.arb_rdata, e.rdata);
               if (e.cyc >= 0) chk("cmplt_latency", 32'(cyc), 32'(e.cyc));
            end
         end else if (bus.ibus_err || bus.dbus_err) begin
            chk("err_without_cmplt", 32'({bus.ibus_err, bus.dbus_err}), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.ibus_req = 1'b0;  bus.ibus_addr = '0; bus.ibus_size = '0; bus.ibus_prot = '0;
      bus.dbus_req = 1'b0;  bus.dbus_addr = '0; bus.dbus_size = '0; bus.dbus_prot = '0;
      bus.dbus_write = 1'b0; bus.dbus_wdata = '0; bus.dbus_lock = 1'b0;
      bus.pad_hrdata = '0;  bus.pad_hready = 1'b1; bus.pad_hresp = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_htrans", 32'(bus.ahbl_htrans), 32'd0);
      chk("rst_haddr", bus.ahbl_haddr, 32'd0);
      chk("rst_arb_idle", 32'(bus.arb_idle), 32'd1);
      chk("rst_cmplt", 32'({bus.ibus_cmplt, bus.dbus_cmplt}), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // ibus read 0x100, zero-wait slave
      bus.ibus_req = 1'b1; bus.ibus_addr = 32'h100; bus.ibus_size = 2'd2; bus.ibus_prot = 4'h3;
      bus.pad_hrdata = 32'hDEADBEEF;
      g_q.push_back(1'b0);
      push_c(1'b0, 1'b0, 32'hDEADBEEF, cyc + 3);
      @(negedge clk);
      chk("req_not_idle", 32'(bus.arb_idle), 32'd0);
      tick();
      bus.ibus_req = 1'b0; bus.ibus_addr = 32'h0;
      @(negedge clk);
      chk("ib_htrans_addr", 32'(bus.ahbl_htrans), 32'd2);
      chk("ib_haddr", bus.ahbl_haddr, 32'h100);
      chk("ib_hsize", 32'(bus.ahbl_hsize), 32'd2);
      chk("ib_hprot", 32'(bus.ahbl_hprot), 32'h3);
      chk("ib_hwrite", 32'(bus.ahbl_hwrite), 32'd0);
      tick();
      @(negedge clk);
      chk("ib_htrans_data", 32'(bus.ahbl_htrans), 32'd0);
      wait_done(20);

      // dbus write 0x200 with two hready-low cycles in ADDR
      tick();
      bus.dbus_req = 1'b1; bus.dbus_addr = 32'h200; bus.dbus_size = 2'd2; bus.dbus_prot = 4'h1;
      bus.dbus_write = 1'b1; bus.dbus_wdata = 32'h55AA; bus.pad_hrdata = 32'h0;
      g_q.push_back(1'b1);
      push_c(1'b1, 1'b0, 32'h0, cyc + 5);
      @(negedge clk);
      tick();
      bus.dbus_req = 1'b0; bus.dbus_write = 1'b0; bus.dbus_wdata = 32'h0; bus.dbus_addr = 32'h0;
      bus.pad_hready = 1'b0;
      @(negedge clk);
      chk("wr_htrans_addr", 32'(bus.ahbl_htrans), 32'd2);
      chk("wr_haddr", bus.ahbl_haddr, 32'h200);
      chk("wr_hwrite", 32'(bus.ahbl_hwrite), 32'd1);
      tick();
      @(negedge clk);
      chk("wr_haddr_hold", bus.ahbl_haddr, 32'h200);
      chk("wr_htrans_hold", 32'(bus.ahbl_htrans), 32'd2);
      tick();
      bus.pad_hready = 1'b1;
      @(negedge clk);
      chk("wr_htrans_last_addr", 32'(bus.ahbl_htrans), 32'd2);
      tick();
      @(negedge clk);
      chk("wr_htrans_data", 32'(bus.ahbl_htrans), 32'd0);
      chk("wr_hwdata", bus.ahbl_hwdata, 32'h55AA);
      chk("wr_haddr_data", bus.ahbl_haddr, 32'h200);
      wait_done(20);

      // Two-cycle ERROR response on a dbus read
      tick();
      bus.dbus_req = 1'b1; bus.dbus_addr = 32'h300; bus.dbus_write = 1'b0;
      bus.pad_hrdata = 32'hBAD00001;
      g_q.push_back(1'b1);
      push_c(1'b1, 1'b1, 32'hBAD00001, cyc + 4);
      @(negedge clk);
      tick();
      bus.dbus_req = 1'b0;
      tick();
      bus.pad_hready = 1'b0; bus.pad_hresp = 1'b1;
      @(negedge clk);
      chk("err_htrans_data", 32'(bus.ahbl_htrans), 32'd0);
      chk("rd_hwdata_zero", bus.ahbl_hwdata, 32'd0);
      tick();
      bus.pad_hready = 1'b1;
      tick();
      bus.pad_hresp = 1'b0;
      wait_done(20);

      // Starvation: both request continuously -> D,D,D,D,I,D
      tick();
      bus.ibus_req = 1'b1; bus.ibus_addr = 32'h1000;
      bus.dbus_req = 1'b1; bus.dbus_addr = 32'h2000;
      bus.pad_hrdata = 32'hC0DE0000;
      g_q.push_back(1'b1); g_q.push_back(1'b1); g_q.push_back(1'b1); g_q.push_back(1'b1);
      g_q.push_back(1'b0); g_q.push_back(1'b1);
      push_c(1'b1, 1'b0, 32'hC0DE0000, -1); push_c(1'b1, 1'b0, 32'hC0DE0000, -1);
      push_c(1'b1, 1'b0, 32'hC0DE0000, -1); push_c(1'b1, 1'b0, 32'hC0DE0000, -1);
      push_c(1'b0, 1'b0, 32'hC0DE0000, -1); push_c(1'b1, 1'b0, 32'hC0DE0000, -1);
      for (int k = 0; k < 5; k++) wait_any(20);
      chk("starve_at_limit", 32'(dut.r_starve_cnt), 32'd4);
      @(negedge clk);
      chk("starve_cleared", 32'(dut.r_starve_cnt), 32'd0);
      wait_any(20);
      tick();
      bus.ibus_req = 1'b0; bus.dbus_req = 1'b0;
      wait_done(40);

      // Locked dbus sequence holds off a waiting ibus
      tick();
      bus.ibus_req = 1'b1; bus.ibus_addr = 32'h180;
      bus.dbus_req = 1'b1; bus.dbus_addr = 32'h500; bus.dbus_lock = 1'b1;
      bus.pad_hrdata = 32'h00000A0A;
      g_q.push_back(1'b1); g_q.push_back(1'b1); g_q.push_back(1'b0);
      push_c(1'b1, 1'b0, 32'h00000A0A, -1); push_c(1'b1, 1'b0, 32'h00000A0A, -1);
      push_c(1'b0, 1'b0, 32'h00000A0A, -1);
      wait_any(20);
      tick();
      @(negedge clk);
      chk("lock_hlock_1", 32'(bus.ahbl_hlock), 32'd1);
      wait_any(20);
      tick();
      bus.dbus_req = 1'b0; bus.dbus_lock = 1'b0;
      @(negedge clk);
      chk("lock_hlock_2", 32'(bus.ahbl_hlock), 32'd1);
      wait_any(20);
      tick();
      bus.ibus_req = 1'b0;
      @(negedge clk);
      chk("unlock_ibus_haddr", bus.ahbl_haddr, 32'h180);
      chk("unlock_hlock", 32'(bus.ahbl_hlock), 32'd0);
      wait_done(20);

      // Reset asserted during DATA aborts the transfer silently
      tick();
      bus.dbus_req = 1'b1; bus.dbus_addr = 32'h400;
      g_q.push_back(1'b1);
      @(negedge clk);
      tick();
      bus.dbus_req = 1'b0;
      tick();
      bus.pad_hready = 1'b0;
      @(negedge clk);
      chk("busy_not_idle", 32'(bus.arb_idle), 32'd0);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_htrans", 32'(bus.ahbl_htrans), 32'd0);
      chk("mid_rst_haddr", bus.ahbl_haddr, 32'd0);
      chk("mid_rst_idle", 32'(bus.arb_idle), 32'd1);
      tick();
      bus.pad_hready = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_rst_no_cmplt", 32'({bus.ibus_cmplt, bus.dbus_cmplt}), 32'd0);
         tick();
      end
      chk("post_rst_idle", 32'(bus.arb_idle), 32'd1);
      wait_done(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
